// File: rtl/alu_pipe_sat.sv
// alu_pipe_sat
// Two-stage pipelined signed saturating ALU with valid/ready handshakes on
// both sides, per-result saturation/illegal flags and a saturation counter.
//
// Stage 1 registers the raw result: ADD/SUB at N+1 bits, MUL as the full
// 2N-bit product, and logic/shift/rotate/compare ops already final.
// Stage 2 applies the FRAC scaling and saturation and registers y/sat/illegal.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          input handshake (opcode, a, b, shift)
//   opcode                     0 NOP,1 ADD,2 SUB,3 MUL,4 AND,5 OR,6 XOR,7 SHL,
//                              8 SHRA,9 SHRL,10 ROL,11 ROR,12 EQ; 13-15 illegal
//   a, b                       signed operands (N bits)
//   shift                      unsigned shift/rotate amount (S bits)
//   out_valid/out_ready        output handshake (y, sat, illegal)
//   sat_count, cnt_clr         saturating count of sat results handed off, clear
module alu_pipe_sat #(
  parameter int N     = 16,
  parameter int FRAC  = 12,
  parameter int S     = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          opcode,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [S-1:0]        shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        y,
  output logic                sat,
  output logic                illegal,
  output logic [CNT_W-1:0]    sat_count,
  input  logic                cnt_clr
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHRA = 4'd8;
  localparam logic [3:0] OP_SHRL = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_EQ   = 4'd12;

  localparam logic [S-1:0] N_S = S'(N);
  localparam logic signed [2*N-1:0] SAT_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] SAT_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  s1_valid;
  logic [3:0]            s1_op;
  logic signed [2*N-1:0] s1_raw;
  logic                  s2_valid;
  logic                  s1_adv;
  logic                  s2_adv;

  logic [N-1:0]          a_u;
  logic [N:0]            add_sum;
  logic [N:0]            sub_diff;
  logic signed [2*N-1:0] mul_prod;
  logic signed [N-1:0]   shra_res;
  logic [S-1:0]          rot_amt;
  logic [N-1:0]          logic_res;
  logic signed [2*N-1:0] s1_raw_d;

  logic signed [2*N-1:0] s2_scaled;
  logic                  is_arith;
  logic                  is_ill;
  logic [N-1:0]          y_d;
  logic                  sat_d;
  logic                  ill_d;

  // Each stage may accept when it is empty or when its content moves on.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = !rst && s1_adv;
  assign out_valid = s2_valid;

  // Stage 1 datapath. Arithmetic keeps enough headroom to detect overflow later.
  always_comb begin
    a_u       = a;
    add_sum   = {a[N-1], a} + {b[N-1], b};
    sub_diff  = {b[N-1], b} - {a[N-1], a};
    mul_prod  = (2*N)'(a) * (2*N)'(b);
    shra_res  = a >>> shift;
    rot_amt   = shift % N_S;
    logic_res = '0;
    case (opcode)
      OP_AND:  logic_res = a_u & b;
      OP_OR:   logic_res = a_u | b;
      OP_XOR:  logic_res = a_u ^ b;
      OP_SHL:  logic_res = (shift >= N_S) ? '0 : (a_u << shift);
      OP_SHRA: logic_res = (shift >= N_S) ? {N{a[N-1]}} : shra_res;
      OP_SHRL: logic_res = (shift >= N_S) ? '0 : (a_u >> shift);
      // A right shift by N yields 0, so rot_amt == 0 returns a unchanged.
      OP_ROL:  logic_res = (a_u << rot_amt) | (a_u >> (N_S - rot_amt));
      OP_ROR:  logic_res = (a_u >> rot_amt) | (a_u << (N_S - rot_amt));
      OP_EQ:   logic_res = {{(N-1){1'b0}}, (a == b)};
      default: logic_res = '0;
    endcase
    case (opcode)
      OP_ADD:  s1_raw_d = {{(N-1){add_sum[N]}}, add_sum};
      OP_SUB:  s1_raw_d = {{(N-1){sub_diff[N]}}, sub_diff};
      OP_MUL:  s1_raw_d = mul_prod;
      default: s1_raw_d = {{N{1'b0}}, logic_res};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_raw   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= opcode;
        s1_raw <= s1_raw_d;
      end
    end
  end

  // Stage 2: fixed-point rescale of the product (arithmetic shift floors
  // toward -inf), then clamp the arithmetic ops to the signed N-bit range.
  always_comb begin
    s2_scaled = (s1_op == OP_MUL) ? (s1_raw >>> FRAC) : s1_raw;
    is_arith  = (s1_op == OP_ADD) || (s1_op == OP_SUB) || (s1_op == OP_MUL);
    is_ill    = (s1_op > OP_EQ);
    y_d       = '0;
    sat_d     = 1'b0;
    ill_d     = 1'b0;
    if (is_ill) begin
      ill_d = 1'b1;
    end else if (is_arith) begin
      if (s2_scaled > SAT_MAX) begin
        y_d   = SAT_MAX[N-1:0];
        sat_d = 1'b1;
      end else if (s2_scaled < SAT_MIN) begin
        y_d   = SAT_MIN[N-1:0];
        sat_d = 1'b1;
      end else begin
        y_d = s2_scaled[N-1:0];
      end
    end else begin
      y_d = s1_raw[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y        <= '0;
      sat      <= 1'b0;
      illegal  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y       <= y_d;
        sat     <= sat_d;
        illegal <= ill_d;
      end
    end
  end

  // Clear beats a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (cnt_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && sat && (sat_count != CNT_MAX)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe_sat.sv
// tb_alu_pipe_sat
// Self-checking bench for alu_pipe_sat. A second instance with a 4-bit
// counter shares all inputs so the counter's hold-at-maximum is reachable
// in a few cycles. Expected results come from an arithmetic reference model
// and an in-flight queue with a capacity of two operations.
module tb_alu_pipe_sat;

  localparam int N    = 16;
  localparam int FRAC = 12;
  localparam int S    = 5;

  typedef struct {
    logic [15:0] y;
    logic        sat;
    logic        ill;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [4:0]  shift = 5'd0;

  logic        in_ready, out_valid, sat, illegal;
  logic [15:0] y;
  logic [15:0] sat_count;
  logic        in_ready_s, out_valid_s, sat_s, illegal_s;
  logic [15:0] y_s;
  logic [3:0]  sat_count_s;

  int          tests = 0;
  int          fails = 0;
  int          cycle_num = 0;
  int          pop_count = 0;
  int          cnt = 0;
  int          cnt_s = 0;
  exp_t        q[$];
  logic        last_accepted = 1'b0;
  logic [15:0] last_y = 16'd0;
  logic        last_sat = 1'b0;
  logic        last_ill = 1'b0;
  int          last_lat = 0;

  alu_pipe_sat #(.N(N), .FRAC(FRAC), .S(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sat(sat),
    .illegal(illegal), .sat_count(sat_count), .cnt_clr(cnt_clr)
  );

  alu_pipe_sat #(.N(N), .FRAC(FRAC), .S(S), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .opcode(opcode), .a(a), .b(b), .shift(shift),
    .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .sat(sat_s),
    .illegal(illegal_s), .sat_count(sat_count_s), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t refModel(input logic [3:0] op, input logic [15:0] av,
                                    input logic [15:0] bv, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, ua, ub, v;
    int     r;
    logic   arith;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = longint'(av);
    ub = longint'(bv);
    r  = int'(sh) % 16;
    v  = 0;
    arith = 1'b0;
    e.sat = 1'b0;
    e.ill = 1'b0;
    e.stamp = 0;
    case (op)
      4'd0:  v = 0;
      4'd1:  begin v = sa + sb; arith = 1'b1; end
      4'd2:  begin v = sb - sa; arith = 1'b1; end
      4'd3:  begin v = (sa * sb) >>> FRAC; arith = 1'b1; end
      4'd4:  v = ua & ub;
      4'd5:  v = ua | ub;
      4'd6:  v = ua ^ ub;
      4'd7:  v = (sh >= 16) ? 0 : ((ua << sh) & 64'hFFFF);
      4'd8:  v = (sh >= 16) ? ((sa < 0) ? -1 : 0) : (sa >>> sh);
      4'd9:  v = (sh >= 16) ? 0 : (ua >> sh);
      4'd10: v = ((ua << r) | (ua >> (16 - r))) & 64'hFFFF;
      4'd11: v = ((ua >> r) | (ua << (16 - r))) & 64'hFFFF;
      4'd12: v = (av == bv) ? 1 : 0;
      default: begin v = 0; e.ill = 1'b1; end
    endcase
    if (arith) begin
      if (v > 32767) begin
        v = 32767;
        e.sat = 1'b1;
      end else if (v < -32768) begin
        v = -32768;
        e.sat = 1'b1;
      end
    end
    e.y = 16'(v);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [15:0] av,
                               input logic [15:0] bv, input logic [4:0] sh);
    in_valid = v;
    opcode   = op;
    a        = av;
    b        = bv;
    shift    = sh;
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // account for both handshakes, then move to just after the rising edge.
  task automatic tick();
    logic exp_in_ready, exp_out_valid, sat_hs;
    exp_t head, e;
    @(negedge clk);
    sat_hs = 1'b0;
    last_accepted = 1'b0;
    exp_in_ready = !rst && ((q.size() < 2) || out_ready);
    exp_out_valid = 1'b0;
    if (q.size() > 0) exp_out_valid = (cycle_num >= q[0].stamp + 2);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_in_ready));
    checkOutput("in_ready_small", 32'(in_ready_s), 32'(exp_in_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_out_valid));
    checkOutput("out_valid_small", 32'(out_valid_s), 32'(exp_out_valid));
    checkOutput("sat_count", 32'(sat_count), cnt);
    checkOutput("sat_count_small", 32'(sat_count_s), cnt_s);
    if (exp_out_valid) begin
      head = q[0];
      checkOutput("y", 32'(y), 32'(head.y));
      checkOutput("sat", 32'(sat), 32'(head.sat));
      checkOutput("illegal", 32'(illegal), 32'(head.ill));
      checkOutput("y_small", 32'(y_s), 32'(head.y));
      if (out_ready) begin
        void'(q.pop_front());
        pop_count++;
        last_y   = y;
        last_sat = sat;
        last_ill = illegal;
        last_lat = cycle_num - head.stamp;
        sat_hs   = head.sat;
      end
    end
    if (in_valid && exp_in_ready) begin
      e = refModel(opcode, a, b, shift);
      e.stamp = cycle_num;
      q.push_back(e);
      last_accepted = 1'b1;
    end
    if (rst) begin
      cnt = 0;
      cnt_s = 0;
      q.delete();
    end else if (cnt_clr) begin
      cnt = 0;
      cnt_s = 0;
    end else if (sat_hs) begin
      if (cnt < 65535) cnt++;
      if (cnt_s < 15) cnt_s++;
    end
    cycle_num++;
    @(posedge clk);
    #1;
  endtask

  // Single operation into an empty pipeline; result checked against constants.
  task automatic runOne(input string tag, input logic [3:0] op, input logic [15:0] av,
                        input logic [15:0] bv, input logic [4:0] sh,
                        input logic [15:0] ey, input logic es, input logic ei);
    int p0;
    int guard;
    p0 = pop_count;
    out_ready = 1'b1;
    applyStimulus(1'b1, op, av, bv, sh);
    tick();
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 5'd0);
    guard = 0;
    while (pop_count == p0 && guard < 10) begin
      tick();
      guard++;
    end
    checkOutput({tag, " handoff"}, pop_count - p0, 1);
    checkOutput({tag, " y"}, 32'(last_y), 32'(ey));
    checkOutput({tag, " sat"}, 32'(last_sat), 32'(es));
    checkOutput({tag, " illegal"}, 32'(last_ill), 32'(ei));
    checkOutput({tag, " latency"}, last_lat, 2);
  endtask

  initial begin
    logic pattern [4];
    int   sent;
    int   cyc;
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;

    // Reset state while rst is still asserted.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset y", 32'(y), 0);
    checkOutput("reset sat", 32'(sat), 0);
    checkOutput("reset illegal", 32'(illegal), 0);
    checkOutput("reset sat_count", 32'(sat_count), 0);
    checkOutput("reset in_ready", 32'(in_ready), 0);
    rst = 1'b0;

    // Saturating add, latency and first count.
    runOne("t1 add", 4'd1, 16'h7000, 16'h2000, 5'd0, 16'h7FFF, 1'b1, 1'b0);
    checkOutput("t1 sat_count", 32'(sat_count), 1);

    // Subtract (b-a) and Q4.12 multiply.
    runOne("t2 sub", 4'd2, 16'h0001, 16'h8000, 5'd0, 16'h8000, 1'b1, 1'b0);
    runOne("t2 mul one", 4'd3, 16'h1000, 16'h1000, 5'd0, 16'h1000, 1'b0, 1'b0);
    runOne("t2 mul sat", 4'd3, 16'h7000, 16'h7000, 5'd0, 16'h7FFF, 1'b1, 1'b0);

    // Shifts beyond the width and rotates.
    runOne("t3 shra", 4'd8, 16'h8000, 16'h0000, 5'd20, 16'hFFFF, 1'b0, 1'b0);
    runOne("t3 shrl", 4'd9, 16'h8000, 16'h0000, 5'd20, 16'h0000, 1'b0, 1'b0);
    runOne("t3 rol", 4'd10, 16'h8001, 16'h0000, 5'd17, 16'h0003, 1'b0, 1'b0);
    runOne("t3 ror", 4'd11, 16'h0001, 16'h0000, 5'd1, 16'h8000, 1'b0, 1'b0);
    runOne("t3 eq", 4'd12, 16'h1234, 16'h1234, 5'd0, 16'h0001, 1'b0, 1'b0);

    // Illegal opcode leaves the counter alone.
    runOne("t6 illegal", 4'd14, 16'h7000, 16'h7000, 5'd0, 16'h0000, 1'b0, 1'b1);
    checkOutput("t6 illegal count", 32'(sat_count), 3);

    // Eight back-to-back ops under a 1,0,0,1 out_ready pattern.
    sent = 0;
    cyc = 0;
    while ((sent < 8 || q.size() > 0) && cyc < 100) begin
      out_ready = pattern[cyc % 4];
      if (sent < 8)
        applyStimulus(1'b1, 4'($urandom_range(0, 12)), 16'($urandom), 16'($urandom),
                      5'($urandom_range(0, 31)));
      else
        applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 5'd0);
      tick();
      if (last_accepted) sent++;
      cyc++;
    end
    checkOutput("t4 all sent", sent, 8);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd1, 16'h7000, 16'h2000, 5'd0);
    tick();
    applyStimulus(1'b1, 4'd6, 16'h00FF, 16'h0F0F, 5'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    checkOutput("t5 out_valid after rst", 32'(out_valid), 0);
    checkOutput("t5 sat_count after rst", 32'(sat_count), 0);
    repeat (4) tick();

    // Counter clear, then hold at maximum on the 4-bit instance.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    applyStimulus(1'b1, 4'd3, 16'h7000, 16'h7000, 5'd0);
    repeat (18) tick();
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 5'd0);
    repeat (4) tick();
    checkOutput("t6 small hold", 32'(sat_count_s), 15);
    checkOutput("t6 main count", 32'(sat_count), 18);

    // Clear coincident with a saturated handoff.
    applyStimulus(1'b1, 4'd1, 16'h7000, 16'h2000, 5'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 5'd0);
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkOutput("t6 clr beat sat", 32'(last_sat), 1);
    checkOutput("t6 clr wins", 32'(sat_count), 0);

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
                    16'($urandom), 5'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clr = ($urandom_range(0, 40) == 0);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 5'd0);
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
